// File: rtl/image_re_pkg.sv
// image_re_pkg: shared types and constants for the image_re decimation core.
package image_re_pkg;

  localparam int PIX_W_DEF = 8;
  localparam int DIM_W_DEF = 12;
  localparam int SHIFT_W   = 2;   // factor = 2^shift, shift in 0..3
  localparam int MASK_W    = 3;   // widest low-bit mask for a factor of 8

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SOF = 2'd1,
    RUN      = 2'd2,
    DRAIN    = 2'd3
  } state_t;

  // Low-bit mask selecting the position inside a group of 2^s pixels/lines.
  function automatic logic [MASK_W-1:0] shift_mask(input logic [SHIFT_W-1:0] s);
    logic [MASK_W-1:0] m;
    case (s)
      2'd0:    m = 3'b000;
      2'd1:    m = 3'b001;
      2'd2:    m = 3'b011;
      default: m = 3'b111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/image_re_out_reg.sv
// image_re_out_reg: single-entry output register with valid/ready handshake.
// A load always wins over a drain, so a same-cycle handshake plus reload keeps valid high.
module image_re_out_reg #(
  parameter int PIX_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [PIX_W-1:0] data_i,
  input  logic             user_i,
  input  logic             last_i,
  input  logic             m_tready_i,
  output logic [PIX_W-1:0] m_tdata_o,
  output logic             m_tvalid_o,
  output logic             m_tuser_o,
  output logic             m_tlast_o
);

  logic [PIX_W-1:0] data_q;
  logic             valid_q, user_q, last_q;

  // Hold the pixel until the consumer takes it; reload whenever the core emits.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      user_q  <= 1'b0;
      last_q  <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      user_q  <= user_i;
      last_q  <= last_i;
    end else if (m_tready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign m_tdata_o  = data_q;
  assign m_tvalid_o = valid_q;
  assign m_tuser_o  = user_q;
  assign m_tlast_o  = last_q;

endmodule

// File: rtl/image_re_decimator.sv
// image_re_decimator: pixel-stream decimator by 2^h_shift x 2^v_shift.
// Define IMAGE_RE_HAVG_EN to replace horizontal pick with a horizontal box average.
//
// state    | meaning
// IDLE     | waiting for cfg_start; config checked and latched here
// WAIT_SOF | discarding beats until one carries s_tuser
// RUN      | counting pixels, emitting the kept ones
// DRAIN    | input closed, waiting for the output register to empty
module image_re_decimator
  import image_re_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF,
  parameter int DIM_W = DIM_W_DEF
) (
  input  logic               ACLK,
  input  logic               ARESET,
  input  logic [DIM_W-1:0]   cfg_width,
  input  logic [DIM_W-1:0]   cfg_height,
  input  logic [SHIFT_W-1:0] cfg_h_shift,
  input  logic [SHIFT_W-1:0] cfg_v_shift,
  input  logic               cfg_start,
  input  logic [PIX_W-1:0]   s_tdata,
  input  logic               s_tvalid,
  output logic               s_tready,
  input  logic               s_tuser,
  input  logic               s_tlast,
  output logic [PIX_W-1:0]   m_tdata,
  output logic               m_tvalid,
  input  logic               m_tready,
  output logic               m_tuser,
  output logic               m_tlast,
  output logic               busy,
  output logic               done,
  output logic               cfg_err,
  output logic               sync_err
);

  state_t             state_q, state_d;
  logic [DIM_W-1:0]   width_q, height_q;
  logic [SHIFT_W-1:0] h_shift_q, v_shift_q;
  logic [DIM_W-1:0]   x_q, x_d, y_q, y_d;
  logic               cfg_err_q, cfg_err_d, sync_err_q, sync_err_d;
  logic               first_q, first_d;
  logic [MASK_W-1:0]  hmask, vmask;
  logic               cfg_bad, accept, proc, x_end, y_end;
  logic               row_keep, grp_hit, emit, emit_last;
  logic [PIX_W-1:0]   emit_data;
`ifdef IMAGE_RE_HAVG_EN
  logic [PIX_W+2:0]   acc_q, acc_sum;
`endif

  assign hmask    = shift_mask(h_shift_q);
  assign vmask    = shift_mask(v_shift_q);
  assign x_end    = (x_q == width_q - DIM_W'(1));
  assign y_end    = (y_q == height_q - DIM_W'(1));
  assign row_keep = ((y_q[MASK_W-1:0] & vmask) == '0);
  assign cfg_bad  = (cfg_width == '0) || (cfg_height == '0) ||
                    ((cfg_width[MASK_W-1:0] & shift_mask(cfg_h_shift)) != '0) ||
                    ((cfg_height[MASK_W-1:0] & shift_mask(cfg_v_shift)) != '0);
  // Last output of a row is the last group of the row, valid for pick and average alike.
  assign emit_last = ((x_q >> h_shift_q) == ((width_q >> h_shift_q) - DIM_W'(1)));

`ifdef IMAGE_RE_HAVG_EN
  // Running group sum including the current beat; restarts on each group's first pixel.
  always_comb begin
    acc_sum   = (((x_q[MASK_W-1:0] & hmask) == '0) ? {(PIX_W+3){1'b0}} : acc_q)
                + (PIX_W+3)'(s_tdata);
    emit_data = PIX_W'(acc_sum >> h_shift_q);
    grp_hit   = ((x_q[MASK_W-1:0] & hmask) == hmask);
  end
`else
  // Pick mode forwards the first pixel of each group unchanged.
  always_comb begin
    emit_data = s_tdata;
    grp_hit   = ((x_q[MASK_W-1:0] & hmask) == '0);
  end
`endif

  // Next-state, counters, error flags and input handshake.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    cfg_err_d  = cfg_err_q;
    sync_err_d = sync_err_q;
    first_d    = first_q;
    s_tready   = 1'b0;
    done       = 1'b0;
    case (state_q)
      WAIT_SOF: s_tready = 1'b1;
      RUN:      s_tready = !m_tvalid || m_tready;
      default:  s_tready = 1'b0;
    endcase
    accept = s_tvalid && s_tready;
    proc   = accept && ((state_q == RUN) || ((state_q == WAIT_SOF) && s_tuser));
    emit   = proc && row_keep && grp_hit;

    case (state_q)
      IDLE: begin
        if (cfg_start) begin
          sync_err_d = 1'b0;
          cfg_err_d  = cfg_bad;
          x_d        = '0;
          y_d        = '0;
          first_d    = 1'b1;
          if (!cfg_bad) state_d = WAIT_SOF;
        end
      end
      WAIT_SOF, RUN: begin
        if (proc) begin
          if (s_tlast != x_end) sync_err_d = 1'b1;
          if ((state_q == RUN) && s_tuser) sync_err_d = 1'b1;
          if (emit) first_d = 1'b0;
          if (x_end) begin
            x_d = '0;
            y_d = y_q + DIM_W'(1);
          end else begin
            x_d = x_q + DIM_W'(1);
          end
          state_d = (x_end && y_end) ? DRAIN : RUN;
        end
      end
      DRAIN: begin
        if (!m_tvalid) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters, sticky flags and latched configuration.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      cfg_err_q  <= 1'b0;
      sync_err_q <= 1'b0;
      first_q    <= 1'b0;
      width_q    <= '0;
      height_q   <= '0;
      h_shift_q  <= '0;
      v_shift_q  <= '0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      cfg_err_q  <= cfg_err_d;
      sync_err_q <= sync_err_d;
      first_q    <= first_d;
      if ((state_q == IDLE) && cfg_start) begin
        width_q   <= cfg_width;
        height_q  <= cfg_height;
        h_shift_q <= cfg_h_shift;
        v_shift_q <= cfg_v_shift;
      end
    end
  end

`ifdef IMAGE_RE_HAVG_EN
  // Group accumulator advances on every counted beat.
  always_ff @(posedge ACLK) begin
    if (ARESET)    acc_q <= '0;
    else if (proc) acc_q <= acc_sum;
  end
`endif

  image_re_out_reg #(.PIX_W(PIX_W)) u_out_reg (
    .clk_i      (ACLK),
    .rst_i      (ARESET),
    .load_i     (emit),
    .data_i     (emit_data),
    .user_i     (first_q),
    .last_i     (emit_last),
    .m_tready_i (m_tready),
    .m_tdata_o  (m_tdata),
    .m_tvalid_o (m_tvalid),
    .m_tuser_o  (m_tuser),
    .m_tlast_o  (m_tlast)
  );

  assign busy     = (state_q != IDLE);
  assign cfg_err  = cfg_err_q;
  assign sync_err = sync_err_q;

endmodule

// File: tb/tb_image_re_decimator.sv
// tb_image_re_decimator: table-driven and randomized frames against a behavioural model.
module tb_image_re_decimator;
  localparam int PIX_W = 8;
  localparam int DIM_W = 12;

  logic             ACLK = 1'b0;
  logic             ARESET;
  logic [DIM_W-1:0] cfg_width, cfg_height;
  logic [1:0]       cfg_h_shift, cfg_v_shift;
  logic             cfg_start;
  logic [PIX_W-1:0] s_tdata, m_tdata;
  logic             s_tvalid, s_tready, s_tuser, s_tlast;
  logic             m_tvalid, m_tready, m_tuser, m_tlast;
  logic             busy, done, cfg_err, sync_err;

  always #5 ACLK = ~ACLK;

  image_re_decimator #(.PIX_W(PIX_W), .DIM_W(DIM_W)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .cfg_width(cfg_width), .cfg_height(cfg_height),
    .cfg_h_shift(cfg_h_shift), .cfg_v_shift(cfg_v_shift), .cfg_start(cfg_start),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .s_tuser(s_tuser), .s_tlast(s_tlast),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tuser(m_tuser), .m_tlast(m_tlast),
    .busy(busy), .done(done), .cfg_err(cfg_err), .sync_err(sync_err)
  );

  typedef struct packed { logic [7:0] d; logic u; logic l; } beat_t;
  // rdy: 0 always ready, 1 toggling, 2 random; dmode: 0 x+8y, 1 random, 2 fixed list
  typedef struct {
    int w; int h; int hs; int vs; int junk; int glitch;
    int rdy; int vrnd; int dmode; int exp_n; int exp_serr;
  } vec_t;

  int    n_vec = 0, n_err = 0;
  beat_t stim_q[$], in_q[$], got_q[$], exp_q[$];
  int    exp_serr;
  logic [7:0] fixed_px [4];
  vec_t  tbl [7];

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic build_stim(input vec_t v);
    beat_t b;
    stim_q.delete();
    for (int j = 0; j < v.junk; j++) begin
      b.d = 8'($urandom); b.u = 1'b0; b.l = 1'($urandom);
      stim_q.push_back(b);
    end
    for (int n = 0; n < v.w * v.h; n++) begin
      int x, y;
      x = n % v.w; y = n / v.w;
      case (v.dmode)
        0:       b.d = 8'(x + 8 * y);
        1:       b.d = 8'($urandom);
        default: b.d = fixed_px[n % 4];
      endcase
      b.u = (n == 0);
      b.l = (x == v.w - 1) || (y == 0 && x == v.glitch);
      stim_q.push_back(b);
    end
  endtask

  // Decimation model: frame starts at the first tuser beat; outputs come from
  // kept rows (y % vf == 0) and per group of hf pixels.
  task automatic model(input vec_t v);
    int hf, vf, st;
    beat_t e;
    hf = 1 << v.hs; vf = 1 << v.vs; st = -1;
    exp_q.delete(); exp_serr = 0;
    for (int i = 0; i < stim_q.size(); i++)
      if (st < 0 && stim_q[i].u) st = i;
    for (int n = 0; n < v.w * v.h; n++) begin
      int x, y;
      beat_t b;
      x = n % v.w; y = n / v.w; b = stim_q[st + n];
      if (b.l != (x == v.w - 1)) exp_serr = 1;
      if (n > 0 && b.u) exp_serr = 1;
      if (y % vf == 0) begin
`ifdef IMAGE_RE_HAVG_EN
        if (x % hf == hf - 1) begin
          int s;
          s = 0;
          for (int k = 0; k < hf; k++) s += stim_q[st + n - k].d;
          e.d = 8'(s / hf);
`else
        if (x % hf == 0) begin
          e.d = b.d;
`endif
          e.u = (exp_q.size() == 0);
          e.l = (x / hf == v.w / hf - 1);
          exp_q.push_back(e);
        end
      end
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int    done_cnt, seen, stall_viol, cyc;
    logic  prev_stall;
    beat_t prev;
    build_stim(v);
    model(v);
    @(negedge ACLK);
    cfg_width = DIM_W'(v.w); cfg_height = DIM_W'(v.h);
    cfg_h_shift = 2'(v.hs); cfg_v_shift = 2'(v.vs); cfg_start = 1'b1;
    @(negedge ACLK);
    cfg_start = 1'b0;
    in_q = stim_q; got_q.delete();
    done_cnt = 0; seen = 0; stall_viol = 0; prev_stall = 1'b0; prev = '0;
    for (cyc = 0; cyc < 6000 && seen == 0; cyc++) begin
      s_tvalid = (in_q.size() > 0) && (v.vrnd == 0 || $urandom_range(0, 3) != 0);
      {s_tdata, s_tuser, s_tlast} = (in_q.size() > 0) ? in_q[0] : '0;
      case (v.rdy)
        0:       m_tready = 1'b1;
        1:       m_tready = (cyc % 2 == 0);
        default: m_tready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (prev_stall && (!m_tvalid || {m_tdata, m_tuser, m_tlast} != prev)) stall_viol++;
      prev_stall = m_tvalid && !m_tready;
      prev = {m_tdata, m_tuser, m_tlast};
      if (s_tvalid && s_tready) void'(in_q.pop_front());
      if (m_tvalid && m_tready) got_q.push_back({m_tdata, m_tuser, m_tlast});
      if (done) begin done_cnt++; seen = 1; end
      @(negedge ACLK);
    end
    s_tvalid = 1'b0; m_tready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      if (done) done_cnt++;
      @(negedge ACLK);
    end
    #1;
    chk({tag, " done_seen"}, seen, 1);
    chk({tag, " done_pulses"}, done_cnt, 1);
    chk({tag, " busy_after"}, busy, 0);
    chk({tag, " cfg_err"}, cfg_err, 0);
    chk({tag, " stall_stable"}, stall_viol, 0);
    chk({tag, " out_count"}, got_q.size(), v.exp_n);
    chk({tag, " model_count"}, got_q.size(), exp_q.size());
    chk({tag, " sync_err"}, sync_err, v.exp_serr);
    chk({tag, " sync_err_model"}, sync_err, exp_serr);
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s beat%0d {d,u,l}", tag, i), got_q[i], exp_q[i]);
  endtask

  task automatic cfg_reject(input int w, input int h, input int hs, input int vs, input string tag);
    @(negedge ACLK);
    cfg_width = DIM_W'(w); cfg_height = DIM_W'(h);
    cfg_h_shift = 2'(hs); cfg_v_shift = 2'(vs); cfg_start = 1'b1; s_tvalid = 1'b1;
    @(negedge ACLK);
    cfg_start = 1'b0;
    #1;
    chk({tag, " cfg_err"}, cfg_err, 1);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " s_tready"}, s_tready, 0);
    s_tvalid = 1'b0;
  endtask

  initial begin
    logic [7:0] pick8 [8];
    vec_t rv, hv;
    pick8 = '{8'd0, 8'd2, 8'd4, 8'd6, 8'd16, 8'd18, 8'd20, 8'd22};
    fixed_px = '{8'd10, 8'd20, 8'd30, 8'd41};
    //          w   h  hs vs junk glitch rdy vrnd dmode exp_n serr
    tbl[0] = '{ 8,  4, 1, 1, 0,  -1,    0,  0,   0,    8,    0};
    tbl[1] = '{ 8,  4, 1, 1, 0,  -1,    1,  0,   0,    8,    0};
    tbl[2] = '{ 8,  4, 1, 1, 3,  -1,    0,  0,   0,    8,    0};
    tbl[3] = '{ 8,  4, 1, 1, 0,   5,    0,  0,   0,    8,    1};
    tbl[4] = '{16,  8, 2, 3, 2,  -1,    2,  1,   1,    4,    0};
    tbl[5] = '{ 1,  1, 0, 0, 1,  -1,    2,  0,   1,    1,    0};
    tbl[6] = '{ 8,  8, 3, 0, 0,  -1,    2,  1,   1,    8,    0};

    ARESET = 1'b1; cfg_width = '0; cfg_height = '0; cfg_h_shift = '0; cfg_v_shift = '0;
    cfg_start = 1'b0; s_tdata = '0; s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0;
    m_tready = 1'b1;
    repeat (3) @(negedge ACLK);
    #1;
    chk("reset m_tvalid", m_tvalid, 0);
    chk("reset m_tdata", m_tdata, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset s_tready", s_tready, 0);
    chk("reset errs", {cfg_err, sync_err}, 0);
    ARESET = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_vec(tbl[i], $sformatf("vec%0d", i));
      if (i == 0) begin
        for (int k = 0; k < got_q.size() && k < 8; k++) begin
          chk($sformatf("frame1 data%0d", k), got_q[k].d, pick8[k]);
          chk($sformatf("frame1 user%0d", k), got_q[k].u, (k == 0));
          chk($sformatf("frame1 last%0d", k), got_q[k].l, (k == 3 || k == 7));
        end
      end
    end

    cfg_reject(6, 4, 2, 0, "rej_w6_h2");
    cfg_reject(8, 3, 0, 1, "rej_h3_v1");
    cfg_reject(0, 4, 0, 0, "rej_w0");
    cfg_reject(4, 0, 0, 0, "rej_h0");
    run_vec(tbl[0], "after_reject");

    for (int r = 0; r < 10; r++) begin
      rv.hs = $urandom_range(0, 3); rv.vs = $urandom_range(0, 3);
      rv.w = $urandom_range(1, 4) << rv.hs; rv.h = $urandom_range(1, 3) << rv.vs;
      rv.junk = $urandom_range(0, 3); rv.glitch = -1;
      rv.rdy = $urandom_range(0, 2); rv.vrnd = $urandom_range(0, 1); rv.dmode = 1;
      rv.exp_n = (rv.w >> rv.hs) * (rv.h >> rv.vs); rv.exp_serr = 0;
      run_vec(rv, $sformatf("rnd%0d", r));
    end

    hv = '{4, 1, 2, 0, 0, -1, 0, 0, 2, 1, 0};
    run_vec(hv, "havg4");
    for (int k = 0; k < got_q.size() && k < 1; k++) begin
`ifdef IMAGE_RE_HAVG_EN
      chk("havg4 value", got_q[k].d, 25);
`else
      chk("havg4 value", got_q[k].d, 10);
`endif
      chk("havg4 user_last", {got_q[k].u, got_q[k].l}, 2'b11);
    end

    // Mid-frame reset with a stalled output pixel and a sticky sync error pending.
    @(negedge ACLK);
    cfg_width = 8; cfg_height = 4; cfg_h_shift = 1; cfg_v_shift = 1; cfg_start = 1'b1;
    @(negedge ACLK);
    cfg_start = 1'b0; m_tready = 1'b0;
    s_tvalid = 1'b1; s_tdata = 8'h55; s_tuser = 1'b1; s_tlast = 1'b1;
    @(negedge ACLK);
    s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0;
    #1;
    chk("midrst pre m_tvalid", m_tvalid, 1);
    chk("midrst pre sync_err", sync_err, 1);
    ARESET = 1'b1;
    @(negedge ACLK);
    #1;
    chk("midrst m_tvalid", m_tvalid, 0);
    chk("midrst m_tdata", m_tdata, 0);
    chk("midrst m_tuser_tlast", {m_tuser, m_tlast}, 0);
    chk("midrst busy_done", {busy, done}, 0);
    chk("midrst s_tready", s_tready, 0);
    chk("midrst errs", {cfg_err, sync_err}, 0);
    ARESET = 1'b0; m_tready = 1'b1;
    run_vec(tbl[1], "after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/image_re_decimator.md
Name: image_re_decimator

Overview:
- Pixel-stream decimation core downstream of the Image_Re AXI4-Lite slave register block.
- The register block supplies the frame geometry, the decimation factors and a start pulse.
- The core consumes an AXI4-Stream-style pixel stream and emits a reduced-size stream.
- Status outputs feed back into readable registers.

Parameters:
- PIX_W, 8, pixel data width in bits.
- DIM_W, 12, width of the frame dimension counters and config fields.

Ports:
- ACLK  in  1  clock.
- ARESET  in  1  synchronous, active-high reset.
- cfg_width  in  DIM_W  input frame width in pixels.
- cfg_height  in  DIM_W  input frame height in lines.
- cfg_h_shift  in  2  horizontal factor = 2^cfg_h_shift (1,2,4,8).
- cfg_v_shift  in  2  vertical factor = 2^cfg_v_shift.
- cfg_start  in  1  one-cycle start pulse (register write strobe).
- s_tdata  in  PIX_W  input pixel.
- s_tvalid  in  1  input valid.
- s_tready  out  1  input ready.
- s_tuser  in  1  start of frame, on the first pixel.
- s_tlast  in  1  end of line.
- m_tdata  out  PIX_W  output pixel.
- m_tvalid  out  1  output valid.
- m_tready  in  1  output ready.
- m_tuser  out  1  output start of frame.
- m_tlast  out  1  output end of line.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse at frame completion.
- cfg_err  out  1  sticky: rejected config.
- sync_err  out  1  sticky: s_tlast/s_tuser mismatch.

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, latched config 0.
- FSM states are IDLE, WAIT_SOF, RUN, DRAIN.
- IDLE, on cfg_start:
  - Latch all cfg_* fields.
  - Clear cfg_err and sync_err.
  - Reject if width==0, height==0, width not a multiple of 2^h_shift, or height not a multiple of 2^v_shift. On rejection set cfg_err and stay IDLE.
  - Otherwise go to WAIT_SOF.
- cfg_start outside IDLE is ignored.
- WAIT_SOF:
  - s_tready=1.
  - Beats with s_tuser=0 are discarded.
  - A beat with s_tuser=1 is processed as pixel (0,0), and the state goes to RUN.
- RUN:
  - s_tready = !m_tvalid || m_tready.
  - Every accepted beat advances the x counter. At x==width-1, x wraps to 0 and y increments.
  - A row is kept when y[v_shift-1:0]==0 (always kept when v_shift=0).
  - Pick mode: in a kept row, a pixel is emitted when x[h_shift-1:0]==0.
- Output register:
  - An emitted pixel loads the output register with one-cycle latency: m_tvalid rises the cycle after acceptance.
  - m_tuser=1 on the first output pixel of the frame.
  - m_tlast=1 on the last output pixel of each kept row.
  - Outputs stay stable while m_tvalid && !m_tready.
- Input sync checking:
  - If s_tlast != (x==width-1) on an accepted beat, set sync_err.
  - If s_tuser=1 on any beat other than (0,0), set sync_err.
  - Counters remain authoritative: no resync.
- Last input pixel (x=width-1, y=height-1) accepted: go to DRAIN.
- DRAIN:
  - s_tready=0.
  - When !m_tvalid (the output has drained), pulse done for 1 cycle and go to IDLE.
- busy=1 in WAIT_SOF, RUN and DRAIN.
- Output size is width>>h_shift by height>>v_shift.
- Simultaneous output handshake and new load in the same cycle: the register reloads and m_tvalid stays 1.
- ARESET mid-frame: immediate return to IDLE, and the pending output pixel is dropped.

Optional Feature:
- Macro IMAGE_RE_HAVG_EN.
- Defined:
  - Horizontal box average replaces pick.
  - A PIX_W+3 accumulator sums each group of 2^h_shift pixels.
  - The output is emitted on the group's last pixel (x[h_shift-1:0] all ones) as sum>>h_shift, truncated.
  - The accumulator clears at every group start.
  - The vertical direction is still pick.
- Undefined: pick mode only, and no accumulator is synthesized.

Decomposition:
- Package image_re_pkg:
  - state enum (IDLE, WAIT_SOF, RUN, DRAIN).
  - DIM_W and PIX_W defaults.
  - Factor/shift width constant.
- One sub-module, image_re_out_reg: the single-entry output register holding tdata/tuser/tlast with the valid/ready handshake.

Test Plan:
- width=8, height=4, h_shift=1, v_shift=1, pixel value = x+8y, m_tready=1 -> 4x2 output {0,2,4,6,16,18,20,22}; m_tuser on 0; m_tlast on 6 and 22; done pulses once; busy low afterwards.
- Same frame with m_tready toggling 1/0 every cycle -> identical output sequence, no dropped or duplicated pixels, m_tdata stable while stalled.
- cfg_width=6, h_shift=2 -> cfg_err=1, state stays IDLE, busy=0, s_tready=0.
- 3 beats with s_tuser=0 before the SOF -> discarded; output identical to scenario 1.
- s_tlast asserted at x=5 of an 8-wide row -> sync_err=1; frame still completes with 8 outputs and done pulses.
- IMAGE_RE_HAVG_EN, width=4, height=1, h_shift=2, pixels {10,20,30,41} -> single output 25 with m_tuser=1 and m_tlast=1; ARESET asserted mid-frame -> all outputs 0 the next cycle.
